mag_arbiter: RTL
================

MAG_ARBITER -- requirements
Module: mag_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, gradient and magnitude width.
REQ-002 SHALL have parameter NUM_REQ_P, default 2, number of requesters (legal 2..4).
REQ-003 SHALL have parameter TAG_DEPTH_P, default 4, maximum number of outstanding issued requests (power of 2, at least 2).
REQ-004 Ports (name, direction, width, meaning), one clock, synchronous active-high reset:
- clk_i, in, 1: clock, all state updates on rising edge.
- rst_i, in, 1: synchronous, active-high reset.
- req_valid_i, in, NUM_REQ_P: per-requester request valid.
- req_ready_o, out, NUM_REQ_P: per-requester request accept.
- req_gx_i, in, NUM_REQ_P*WIDTH_P: packed gx operands; requester k uses slice k.
- req_gy_i, in, NUM_REQ_P*WIDTH_P: packed gy operands; requester k uses slice k.
- mag_valid_o, out, 1: issue to the shared magnitude unit.
- mag_ready_i, in, 1: the shared unit accepts the issue.
- mag_gx_o, out, WIDTH_P: issued gx.
- mag_gy_o, out, WIDTH_P: issued gy.
- mag_valid_i, in, 1: result valid from the shared unit.
- mag_ready_o, out, 1: result accept to the shared unit.
- mag_i, in, WIDTH_P: result magnitude.
- rsp_valid_o, out, NUM_REQ_P: per-requester result valid.
- rsp_ready_i, in, NUM_REQ_P: per-requester result accept.
- rsp_mag_o, out, NUM_REQ_P*WIDTH_P: packed results.
- grant_cnt_o, out, NUM_REQ_P*16: per-requester issue counts.
- stall_cnt_o, out, 16: tag-full stall count.

Function
REQ-005 SHALL share one in-order magnitude unit of arbitrary latency among NUM_REQ_P requesters via valid/ready on every interface.
REQ-006 Issue path SHALL be combinational (zero added latency): mag_valid_o = (any req_valid_i) & !tag_full; operands taken from the granted requester.
REQ-007 Grant SHALL be round-robin: search starts at rr_ptr; after each issue handshake (mag_valid_o & mag_ready_i), rr_ptr <= (granted index + 1) mod NUM_REQ_P.
REQ-008 While mag_valid_o=1 and mag_ready_i=0, the grant SHALL be locked (lock flag plus locked index registered); operands and mag_valid_o SHALL stay stable until the handshake, even if other requesters assert.
REQ-009 req_ready_o[k] SHALL be 1 only when k is granted, mag_ready_i=1 and tag_full=0.
REQ-010 Each issue SHALL push the granted index into a tag FIFO of depth TAG_DEPTH_P; tag_full=1 blocks issue.
REQ-011 Return path: while the tag FIFO is non-empty, head index h SHALL route mag_i to rsp_mag_o slice h with rsp_valid_o[h]=mag_valid_i; mag_ready_o=rsp_ready_i[h]; the tag is popped on the mag_valid_i & mag_ready_o handshake.
REQ-012 With the tag FIFO empty, mag_ready_o SHALL be 0 and all rsp_valid_o SHALL be 0.
REQ-013 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged, including when full (push allowed only if not full before the cycle).
REQ-014 Pointer and occupancy arithmetic SHALL wrap modulo TAG_DEPTH_P with an explicit count of width clog2(TAG_DEPTH_P)+1.
REQ-015 rsp_mag_o slices other than the head SHALL drive 0.

Reset
REQ-016 On rst_i=1 at a clock edge: rr_ptr=0, lock=0, tag FIFO empty, counters=0.
REQ-017 During reset, mag_valid_o, req_ready_o, mag_ready_o and rsp_valid_o SHALL be 0.
REQ-018 Reset mid-operation SHALL discard outstanding tags; the environment must also reset the shared unit.

Configuration
REQ-019 Macro MAG_ARB_STATS_EN defined: grant_cnt_o[k] SHALL increment per issue handshake from k; stall_cnt_o SHALL increment each cycle with any req_valid_i=1 and tag_full=1; both saturate at 0xFFFF.
REQ-020 Macro MAG_ARB_STATS_EN undefined: the counter logic SHALL be absent and grant_cnt_o and stall_cnt_o SHALL be tied to 0.

Structure
REQ-021 Package mag_pkg SHALL hold the tag index typedef, the counter width constant (16) and the stats struct type.
REQ-022 The tag FIFO SHALL be a sub-module mag_tag_fifo (parameters width and depth; push/pop/full/empty).

Verification
REQ-023 Both requesters continuously valid, unit always ready, fixed latency 3: grants alternate 0,1,0,1; each requester receives its own gx+gy results, saturated to 255.
REQ-024 Requester 0 sends gx=200, gy=100 while mag_ready_i is held 0 for 5 cycles and requester 1 raises valid: mag_gx_o/mag_gy_o stay 200/100 and the grant stays 0 until accept.
REQ-025 TAG_DEPTH_P=4 with the unit never returning: exactly 4 issues, then mag_valid_o=0 and stall_cnt_o increments each cycle (with macro).
REQ-026 Head tag=1 with rsp_ready_i[1]=0 for 3 cycles: mag_ready_o=0 and the result is held; on release, rsp_valid_o[1] handshakes exactly once.
REQ-027 rst_i asserted with 3 tags outstanding: the next cycle shows all valids/readies 0, FIFO empty and rr_ptr=0; traffic resumes with a grant to requester 0.

Source files
------------

// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared types, constants and helpers for the magnitude arbiter
package mag_pkg;

  // Counter width for grant/stall statistics
  localparam int CNT_W   = 16;
  // Largest supported requester count; tag indices are sized for it
  localparam int MAX_REQ = 4;

  typedef logic [1:0]       tag_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t [MAX_REQ-1:0] grant;
    cnt_t               stall;
  } stats_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  // Saturating increment: sticks at all-ones
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mag_arbiter_if.sv
// rtl/mag_arbiter_if.sv - bundle of requester, shared-unit and response signals
interface mag_arbiter_if #(
  parameter int WIDTH_P   = 8,
  parameter int NUM_REQ_P = 2
);
  logic [NUM_REQ_P-1:0]         req_valid;
  logic [NUM_REQ_P-1:0]         req_ready;
  logic [NUM_REQ_P*WIDTH_P-1:0] req_gx;
  logic [NUM_REQ_P*WIDTH_P-1:0] req_gy;
  logic                         iss_valid;
  logic                         iss_ready;
  logic [WIDTH_P-1:0]           iss_gx;
  logic [WIDTH_P-1:0]           iss_gy;
  logic                         res_valid;
  logic                         res_ready;
  logic [WIDTH_P-1:0]           res_mag;
  logic [NUM_REQ_P-1:0]         rsp_valid;
  logic [NUM_REQ_P-1:0]         rsp_ready;
  logic [NUM_REQ_P*WIDTH_P-1:0] rsp_mag;
  logic [NUM_REQ_P*16-1:0]      grant_cnt;
  logic [15:0]                  stall_cnt;

  // Arbiter side
  modport slave (
    input  req_valid, req_gx, req_gy, iss_ready, res_valid, res_mag, rsp_ready,
    output req_ready, iss_valid, iss_gx, iss_gy, res_ready, rsp_valid, rsp_mag,
           grant_cnt, stall_cnt
  );

  // Environment side: requesters, shared unit and response consumers
  modport master (
    output req_valid, req_gx, req_gy, iss_ready, res_valid, res_mag, rsp_ready,
    input  req_ready, iss_valid, iss_gx, iss_gy, res_ready, rsp_valid, rsp_mag,
           grant_cnt, stall_cnt
  );
endinterface

// File: rtl/mag_tag_fifo.sv
// rtl/mag_tag_fifo.sv - in-order FIFO of requester indices for outstanding issues
module mag_tag_fifo #(
  parameter int WIDTH_P = 2,
  parameter int DEPTH_P = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [WIDTH_P-1:0] push_data_i,
  input  logic               pop_i,
  output logic [WIDTH_P-1:0] pop_data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int PTR_W = $clog2(DEPTH_P);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH_P-1:0] r_mem [DEPTH_P];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o     = (r_count == CNT_W'(DEPTH_P));
  assign empty_o    = (r_count == '0);
  // Push is judged against occupancy before the cycle, so a full FIFO
  // refuses a push even when a pop happens alongside it
  assign w_push     = push_i & ~full_o;
  assign w_pop      = pop_i & ~empty_o;
  assign pop_data_o = r_mem[r_rd_ptr];

  // Pointers wrap naturally (depth is a power of 2); count tracks occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end
endmodule

// File: rtl/mag_arbiter.sv
// rtl/mag_arbiter.sv - round-robin sharing of one in-order magnitude unit (stats: MAG_ARB_STATS_EN)
module mag_arbiter
  import mag_pkg::*;
#(
  parameter int WIDTH_P     = 8,
  parameter int NUM_REQ_P   = 2,
  parameter int TAG_DEPTH_P = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ_P-1:0]         req_valid_i,
  output logic [NUM_REQ_P-1:0]         req_ready_o,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] req_gx_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] req_gy_i,
  output logic                         mag_valid_o,
  input  logic                         mag_ready_i,
  output logic [WIDTH_P-1:0]           mag_gx_o,
  output logic [WIDTH_P-1:0]           mag_gy_o,
  input  logic                         mag_valid_i,
  output logic                         mag_ready_o,
  input  logic [WIDTH_P-1:0]           mag_i,
  output logic [NUM_REQ_P-1:0]         rsp_valid_o,
  input  logic [NUM_REQ_P-1:0]         rsp_ready_i,
  output logic [NUM_REQ_P*WIDTH_P-1:0] rsp_mag_o,
  output logic [NUM_REQ_P*CNT_W-1:0]   grant_cnt_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);
  localparam int TAG_W = $bits(tag_idx_t);

  lock_state_t        r_state;
  lock_state_t        w_state_nxt;
  tag_idx_t           r_rr_ptr;
  tag_idx_t           r_lock_idx;
  tag_idx_t           w_grant;
  tag_idx_t           w_head;
  logic [MAX_REQ-1:0] w_req_valid_ext;
  logic [MAX_REQ-1:0] w_rsp_ready_ext;
  logic               w_full;
  logic               w_empty;
  logic               w_issue;
  logic               w_ret_active;
  logic               w_pop;

  // Widen per-requester vectors so a tag index selects them at exact width
  assign w_req_valid_ext = MAX_REQ'(req_valid_i);
  assign w_rsp_ready_ext = MAX_REQ'(rsp_ready_i);

  // Grant: locked index while an issue is pending, else first valid from rr_ptr
  always_comb begin
    w_grant = r_rr_ptr;
    if (r_state == ST_LOCKED) begin
      w_grant = r_lock_idx;
    end else begin
      // Walk offsets high-to-low so the lowest offset from rr_ptr wins
      for (int i = NUM_REQ_P - 1; i >= 0; i--) begin
        if (w_req_valid_ext[tag_idx_t'((int'(r_rr_ptr) + i) % NUM_REQ_P)])
          w_grant = tag_idx_t'((int'(r_rr_ptr) + i) % NUM_REQ_P);
      end
    end
  end

  assign mag_valid_o = ~rst_i & ~w_full & w_req_valid_ext[w_grant];
  assign w_issue     = mag_valid_o & mag_ready_i;

  // Operand mux and per-requester accept for the granted requester
  always_comb begin
    mag_gx_o    = '0;
    mag_gy_o    = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (w_grant == tag_idx_t'(k)) begin
        mag_gx_o       = req_gx_i[k*WIDTH_P +: WIDTH_P];
        mag_gy_o       = req_gy_i[k*WIDTH_P +: WIDTH_P];
        req_ready_o[k] = w_issue;
      end
    end
  end

  // Lock FSM next state: hold the grant while the unit stalls an offered issue
  always_comb begin
    w_state_nxt = ST_OPEN;
    if (mag_valid_o && !mag_ready_i) w_state_nxt = ST_LOCKED;
  end

  // Lock state, locked index and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_OPEN;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_grant;
      if (w_issue)
        r_rr_ptr <= (w_grant == tag_idx_t'(NUM_REQ_P - 1)) ? '0 : w_grant + tag_idx_t'(1);
    end
  end

  mag_tag_fifo #(
    .WIDTH_P (TAG_W),
    .DEPTH_P (TAG_DEPTH_P)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_issue),
    .push_data_i (w_grant),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign w_ret_active = ~rst_i & ~w_empty;
  assign mag_ready_o  = w_ret_active & w_rsp_ready_ext[w_head];
  assign w_pop        = mag_valid_i & mag_ready_o;

  // Route the returning result to the requester at the head of the tag FIFO
  always_comb begin
    rsp_valid_o = '0;
    rsp_mag_o   = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (w_ret_active && (w_head == tag_idx_t'(k))) begin
        rsp_valid_o[k]                  = mag_valid_i;
        rsp_mag_o[k*WIDTH_P +: WIDTH_P] = mag_i;
      end
    end
  end

`ifdef MAG_ARB_STATS_EN
  stats_t r_stats;
  logic   w_any;

  assign w_any = |req_valid_i;

  // Saturating issue counts per requester and tag-full stall count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stats <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ_P; k++) begin
        if (w_issue && (w_grant == tag_idx_t'(k)))
          r_stats.grant[k] <= sat_inc(r_stats.grant[k]);
      end
      if (w_any && w_full) r_stats.stall <= sat_inc(r_stats.stall);
    end
  end

  // Flatten per-requester counters onto the packed output
  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ_P; k++) grant_cnt_o[k*CNT_W +: CNT_W] = r_stats.grant[k];
  end

  assign stall_cnt_o = r_stats.stall;
`else
  assign grant_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif
endmodule
